cache_control: RTL

//  Control FSM for the LC-3b 2-way set-associative write-back cache (8 sets, 16 B lines).
//  - Inputs: CPU requests and datapath tag-compare and valid/dirty status.
//  - Drives the physical-memory handshake and the datapath load enables.
//  - Drives pmem_address_sel and lru, which the downstream address generator uses to pick the CPU line address or the victim writeback address.
//  - Holds the per-set LRU bits and the hit/miss performance counters.

---
 rtl/cache_control_pkg.sv | 27 ++
 rtl/cache_control_if.sv | 47 ++++
 rtl/cache_control_lru_array.sv | 27 ++
 rtl/cache_control.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cache_control_pkg.sv
// Shared types and sizing for the LC-3b 2-way write-back cache controller.
// Also holds the victim-selection rule used in IDLE.
package cache_control_pkg;

    localparam int NUM_SETS      = 8;
    localparam int SET_W         = $clog2(NUM_SETS);
    localparam int CNT_W         = 16;
    localparam int LC3B_NUM_SETS = NUM_SETS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } lc3b_cache_state;

    // An empty way is always preferred over evicting; way 0 fills first.
    function automatic logic pick_victim(input logic valid0, input logic valid1,
                                         input logic lru_bit);
        if (!valid0)
            return 1'b0;
        else if (!valid1)
            return 1'b1;
        else
            return lru_bit;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU / datapath / physical-memory signal bundle seen by the cache controller.
// master = datapath and memory side, slave = cache_control.
interface cache_control_if;
    import cache_control_pkg::*;

    logic             mem_read;
    logic             mem_write;
    logic [SET_W-1:0] set;
    logic             hit0;
    logic             hit1;
    logic             valid0;
    logic             valid1;
    logic             dirty0;
    logic             dirty1;
    logic             pmem_resp;

    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_address_sel;
    logic             lru;
    logic             load_way0;
    logic             load_way1;
    logic             data_src_sel;
    logic             load_dirty0;
    logic             load_dirty1;
    logic             dirty_in;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output mem_read, mem_write, set, hit0, hit1, valid0, valid1,
               dirty0, dirty1, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address_sel, lru,
               load_way0, load_way1, data_src_sel, load_dirty0, load_dirty1,
               dirty_in, hit_count, miss_count
    );

    modport slave (
        input  mem_read, mem_write, set, hit0, hit1, valid0, valid1,
               dirty0, dirty1, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address_sel, lru,
               load_way0, load_way1, data_src_sel, load_dirty0, load_dirty1,
               dirty_in, hit_count, miss_count
    );

endinterface

// File: rtl/cache_control_lru_array.sv
// Per-set LRU bit storage: one bit per set naming the way to evict next.
// Combinational read, registered write, synchronous active-low clear.
module cache_lru_array #(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SET_W-1:0] waddr,
    input  logic             wdata,
    input  logic [SET_W-1:0] raddr,
    output logic             rdata
);

    logic [NUM_SETS-1:0] bits;

    always_ff @(posedge clk) begin
        if (!rst_n)
            bits <= '0;
        else if (we)
            bits[waddr] <= wdata;
    end

    assign rdata = bits[raddr];

endmodule

// File: rtl/cache_control.sv
// Control FSM for the LC-3b 2-way set-associative write-back cache.
// Hits complete combinationally in IDLE; misses walk WRITEBACK/ALLOCATE then replay.
module cache_control
    import cache_control_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    cache_control_if.slave bus
);

    lc3b_cache_state  state;
    logic             victim_q;
    logic             replay_q;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    logic req;
    logic hit;
    logic hit_way;
    logic lru_rdata;
    logic lru_we;
    logic lru_wdata;
    logic victim;
    logic victim_valid;
    logic victim_dirty;

    assign req          = bus.mem_read | bus.mem_write;
    assign hit          = bus.hit0 | bus.hit1;
    assign hit_way      = bus.hit1;
    assign victim       = pick_victim(bus.valid0, bus.valid1, lru_rdata);
    assign victim_valid = victim ? bus.valid1 : bus.valid0;
    assign victim_dirty = victim ? bus.dirty1 : bus.dirty0;

    cache_lru_array #(
        .NUM_SETS (NUM_SETS),
        .SET_W    (SET_W)
    ) u_lru (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lru_we),
        .waddr (bus.set),
        .wdata (lru_wdata),
        .raddr (bus.set),
        .rdata (lru_rdata)
    );

    always_comb begin
        bus.mem_resp         = 1'b0;
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.pmem_address_sel = 1'b0;
        bus.lru              = 1'b0;
        bus.load_way0        = 1'b0;
        bus.load_way1        = 1'b0;
        bus.data_src_sel     = 1'b0;
        bus.load_dirty0      = 1'b0;
        bus.load_dirty1      = 1'b0;
        bus.dirty_in         = 1'b0;
        lru_we               = 1'b0;
        lru_wdata            = 1'b0;

        unique case (state)
            IDLE: begin
                bus.lru = victim;
                if (req && hit) begin
                    bus.mem_resp = 1'b1;
                    lru_we       = 1'b1;
                    lru_wdata    = ~hit_way;
                    // mem_write wins when both strobes are high
                    if (bus.mem_write) begin
                        bus.load_way0    = ~hit_way;
                        bus.load_way1    = hit_way;
                        bus.load_dirty0  = ~hit_way;
                        bus.load_dirty1  = hit_way;
                        bus.data_src_sel = 1'b1;
                        bus.dirty_in     = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write       = 1'b1;
                bus.pmem_address_sel = 1'b1;
                bus.lru              = victim_q;
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                bus.lru       = victim_q;
                if (bus.pmem_resp) begin
                    bus.load_way0   = ~victim_q;
                    bus.load_way1   = victim_q;
                    bus.load_dirty0 = ~victim_q;
                    bus.load_dirty1 = victim_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            victim_q   <= 1'b0;
            replay_q   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        // the replayed access after a fill is not a first-try hit
                        if (replay_q)
                            replay_q <= 1'b0;
                        else if (hit_count != '1)
                            hit_count <= hit_count + 1'b1;
                    end else if (req) begin
                        victim_q <= victim;
                        if (miss_count != '1)
                            miss_count <= miss_count + 1'b1;
                        state <= (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp)
                        state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        replay_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hit_count  = hit_count;
    assign bus.miss_count = miss_count;

endmodule
